// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch front end; drives the shared Add16 adder and imem fetch requests.
// Optional return-address stack (call_en/ret_en/ras_err) enabled by defining CALL_STACK_EN.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [15:0] branch_off,
  input  logic        jump_en,
  input  logic [15:0] jump_tgt,
  input  logic        halt_req,
  input  logic        resume,
  output logic [15:0] pc,
  output logic        halted
`ifdef CALL_STACK_EN
  ,
  input  logic        call_en,
  input  logic        ret_en,
  output logic        ras_err
`endif
);

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic           imem_req_q, imem_req_d;
  logic           halted_q, halted_d;
  logic           in_fetch;
  logic           take;
  logic           call_sel;
  logic           ret_sel;

`ifdef CALL_STACK_EN
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [W-1:0]   ras_q [RAS_DEPTH];
  logic [W-1:0]   ras_d [RAS_DEPTH];
  logic [PW-1:0]  ptr_q, ptr_d, ptr_dec, ptr_inc;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ras_err_q, ras_err_d;

  assign call_sel = call_en;
  assign ret_sel  = ret_en;
  assign ras_err  = ras_err_q;
  assign ptr_dec  = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : PW'(ptr_q - 1'b1);
  assign ptr_inc  = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : PW'(ptr_q + 1'b1);
`else
  assign call_sel = 1'b0;
  assign ret_sel  = 1'b0;
`endif

  assign in_fetch  = (state_q == S_FETCH);
  assign take      = in_fetch && !stall;
  assign add_a     = pc_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign imem_req  = imem_req_q;
  assign halted    = halted_q;

  // Offset only when a relative branch actually wins; calls need pc+1 for the return address.
  always_comb begin
    add_b = 16'h0001;
    if (in_fetch && branch_en && !jump_en && !call_sel && !ret_sel) add_b = branch_off;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_req_d = imem_req_q;
    halted_d   = halted_q;
`ifdef CALL_STACK_EN
    ras_d      = ras_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ras_err_d  = 1'b0;
`endif
    case (state_q)
      S_BOOT: begin
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
      end
      S_FETCH: begin
        if (take) begin
          if (ret_sel) begin
`ifdef CALL_STACK_EN
            if (cnt_q == '0) begin
              ras_err_d = 1'b1;
            end else begin
              pc_d  = ras_q[ptr_dec];
              ptr_d = ptr_dec;
              cnt_d = CW'(cnt_q - 1'b1);
            end
`endif
          end else if (call_sel) begin
            pc_d = jump_tgt;
`ifdef CALL_STACK_EN
            // Circular stack: a push when full silently overwrites the oldest entry.
            ras_d[ptr_q] = add_sum;
            ptr_d        = ptr_inc;
            if (cnt_q != CW'(RAS_DEPTH)) cnt_d = CW'(cnt_q + 1'b1);
`endif
          end else if (jump_en) begin
            pc_d = jump_tgt;
          end else if (branch_en || imem_ack) begin
            pc_d = add_sum;
          end
        end
        if (halt_req) begin
          state_d    = S_HALTED;
          imem_req_d = 1'b0;
          halted_d   = 1'b1;
        end
      end
      S_HALTED: begin
        if (resume && !halt_req) begin
          state_d    = S_FETCH;
          imem_req_d = 1'b1;
          halted_d   = 1'b0;
        end
      end
      default: begin
        state_d    = S_BOOT;
        imem_req_d = 1'b0;
        halted_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      imem_req_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      imem_req_q <= imem_req_d;
      halted_q   <= halted_d;
    end
  end

`ifdef CALL_STACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      ras_err_q <= 1'b0;
    end else begin
      ras_q     <= ras_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      ras_err_q <= ras_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; covers CALL_STACK_EN scenarios when that macro is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] add_a, add_b, add_sum, imem_addr, pc;
  logic [15:0] add_a2, add_b2, add_sum2, imem_addr2, pc2;
  logic        imem_req, halted, imem_req2, halted2;
  logic        imem_ack, stall, branch_en, jump_en, halt_req, resume;
  logic [15:0] branch_off, jump_tgt;
`ifdef CALL_STACK_EN
  logic        call_en, ret_en, ras_err, ras_err2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Add16 stand-in for each instance
  assign add_sum  = add_a + add_b;
  assign add_sum2 = add_a2 + add_b2;

  pc_sequencer #(.RESET_VECTOR(16'h0000), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .stall(stall),
    .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en), .jump_tgt(jump_tgt),
    .halt_req(halt_req), .resume(resume), .pc(pc), .halted(halted)
`ifdef CALL_STACK_EN
    , .call_en(call_en), .ret_en(ret_en), .ras_err(ras_err)
`endif
  );

  pc_sequencer #(.RESET_VECTOR(16'hFFFE), .RAS_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
    .imem_addr(imem_addr2), .imem_req(imem_req2), .imem_ack(imem_ack), .stall(stall),
    .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en), .jump_tgt(jump_tgt),
    .halt_req(halt_req), .resume(resume), .pc(pc2), .halted(halted2)
`ifdef CALL_STACK_EN
    , .call_en(call_en), .ret_en(ret_en), .ras_err(ras_err2)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 1'b0; stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0;
    halt_req = 1'b0; resume = 1'b0; branch_off = 16'h0000; jump_tgt = 16'h0000;
`ifdef CALL_STACK_EN
    call_en = 1'b0; ret_en = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    imem_ack = 1'b1;
    rst_n = 1'b0;
    step();
    n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL reset_pc got %h exp 0000", pc); end
    n_cmp++; if (pc2 !== 16'hFFFE) begin n_bad++; $display("FAIL reset_pc2 got %h exp fffe", pc2); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %b exp 0", halted); end
    n_cmp++; if (add_b !== 16'h0001) begin n_bad++; $display("FAIL reset_add_b got %h exp 0001", add_b); end
`ifdef CALL_STACK_EN
    n_cmp++; if (ras_err !== 1'b0) begin n_bad++; $display("FAIL reset_ras_err got %b exp 0", ras_err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL boot_req got %b exp 0", imem_req); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_a [4];
    logic [15:0] exp_b [3];
    exp_a = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    exp_b = '{16'hFFFE, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== exp_a[i]) begin
        n_bad++; $display("FAIL seq_addr[%0d] got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, exp_a[i]);
      end
      if (i < 3) begin
        n_cmp++; if (imem_addr2 !== exp_b[i]) begin
          n_bad++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, imem_addr2, exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 13; i++) step();
    n_cmp++; if (pc !== 16'h0010) begin n_bad++; $display("FAIL pre_branch_pc got %h exp 0010", pc); end
    imem_ack = 1'b0; branch_en = 1'b1; branch_off = 16'hFFFC;
    #1;
    n_cmp++; if (add_b !== 16'hFFFC) begin n_bad++; $display("FAIL branch_add_b got %h exp fffc", add_b); end
    step();
    n_cmp++; if (pc !== 16'h000C) begin n_bad++; $display("FAIL branch_pc got %h exp 000c", pc); end
    jump_en = 1'b1; jump_tgt = 16'h1234;
    step();
    n_cmp++; if (pc !== 16'h1234) begin n_bad++; $display("FAIL jump_prio_pc got %h exp 1234", pc); end
    clear_inputs();
    step();
    n_cmp++; if (pc !== 16'h1234) begin n_bad++; $display("FAIL no_ack_hold got %h exp 1234", pc); end
  endtask

  task automatic test_stall();
    stall = 1'b1; imem_ack = 1'b1; branch_en = 1'b1; branch_off = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (pc !== 16'h1234 || imem_req !== 1'b1) begin
        n_bad++; $display("FAIL stall[%0d] got pc=%h req=%b exp pc=1234 req=1", i, pc, imem_req);
      end
    end
    stall = 1'b0; branch_en = 1'b0;
    step();
    n_cmp++; if (pc !== 16'h1235) begin n_bad++; $display("FAIL stall_release got %h exp 1235", pc); end
    step();
    n_cmp++; if (pc !== 16'h1236) begin n_bad++; $display("FAIL stall_seq got %h exp 1236", pc); end
  endtask

  task automatic test_halt();
    jump_en = 1'b1; jump_tgt = 16'h0005;
    step();
    jump_en = 1'b0;
    n_cmp++; if (pc !== 16'h0005) begin n_bad++; $display("FAIL halt_setup got %h exp 0005", pc); end
    halt_req = 1'b1;
    step();
    n_cmp++; if (pc !== 16'h0006 || halted !== 1'b1 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL halt_enter got pc=%h halted=%b req=%b exp 0006/1/0", pc, halted, imem_req);
    end
    resume = 1'b1; jump_en = 1'b1; jump_tgt = 16'h4000;
    step();
    n_cmp++; if (pc !== 16'h0006 || halted !== 1'b1) begin
      n_bad++; $display("FAIL halt_both got pc=%h halted=%b exp 0006/1", pc, halted);
    end
    halt_req = 1'b0; jump_en = 1'b0;
    step();
    n_cmp++; if (pc !== 16'h0006 || halted !== 1'b0 || imem_req !== 1'b1) begin
      n_bad++; $display("FAIL resume got pc=%h halted=%b req=%b exp 0006/0/1", pc, halted, imem_req);
    end
    resume = 1'b0;
    step();
    n_cmp++; if (pc !== 16'h0007) begin n_bad++; $display("FAIL post_resume got %h exp 0007", pc); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pc !== 16'h0000 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL async_reset got pc=%h req=%b exp 0000/0", pc, imem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    n_cmp++; if (pc !== 16'h0001) begin n_bad++; $display("FAIL after_reset got %h exp 0001", pc); end
  endtask

`ifdef CALL_STACK_EN
  task automatic test_call_stack();
    clear_inputs();
    do_reset();
    step();
    jump_en = 1'b1; jump_tgt = 16'h0020;
    step();
    jump_en = 1'b0;
    call_en = 1'b1; jump_tgt = 16'h0100; branch_en = 1'b1; branch_off = 16'h0050;
    #1;
    n_cmp++; if (add_b !== 16'h0001) begin n_bad++; $display("FAIL call_add_b got %h exp 0001", add_b); end
    step();
    n_cmp++; if (pc !== 16'h0100) begin n_bad++; $display("FAIL call_pc got %h exp 0100", pc); end
    call_en = 1'b0; branch_en = 1'b0; ret_en = 1'b1;
    step();
    n_cmp++; if (pc !== 16'h0021 || ras_err !== 1'b0) begin
      n_bad++; $display("FAIL ret_pc got pc=%h err=%b exp 0021/0", pc, ras_err);
    end
    step();
    n_cmp++; if (pc !== 16'h0021 || ras_err !== 1'b1) begin
      n_bad++; $display("FAIL ret_empty got pc=%h err=%b exp 0021/1", pc, ras_err);
    end
    ret_en = 1'b0; imem_ack = 1'b1;
    step();
    n_cmp++; if (pc !== 16'h0022 || ras_err !== 1'b0) begin
      n_bad++; $display("FAIL err_pulse got pc=%h err=%b exp 0022/0", pc, ras_err);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_halt();
    test_async_reset();
`ifdef CALL_STACK_EN
    test_call_stack();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
